// File: rtl/check_ram.sv
// ============================================================================
//  Module   : check_ram
//  Purpose  : AXI4 read master that sweeps the whole RAM in fixed-size INCR
//             bursts and checks every beat against the incrementing fill
//             pattern, reporting pass/fail, an error count and the address
//             of the first bad beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module check_ram #(
    parameter int          DW         = 512,
    parameter int          AW         = 16,
    parameter logic [31:0] FIRST_DATA = 32'hC000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   error_count,
    output logic [AW-1:0] first_error_addr,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [3:0]    M_AXI_ARID,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic          M_AXI_ARLOCK,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    localparam int RAM_SIZE        = 65536;
    localparam int BLOCK_SIZE      = 4096;
    localparam int BEAT_BYTES      = DW / 8;
    localparam int BEATS_PER_BLOCK = BLOCK_SIZE / BEAT_BYTES;
    localparam int MAX_BLOCKS      = RAM_SIZE / BLOCK_SIZE;
    localparam int BEAT_W          = $clog2(BEATS_PER_BLOCK);
    localparam int BLK_W           = $clog2(MAX_BLOCKS + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS_PER_BLOCK - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK   = BLK_W'(MAX_BLOCKS);
    localparam logic [AW-1:0]     ADDR_STEP  = AW'(BLOCK_SIZE);
    localparam logic [AW-1:0]     BEAT_STEP  = AW'(BEAT_BYTES);
    localparam logic [DW-1:0]     FIRST_EXP  = {{(DW-32){1'b0}}, FIRST_DATA};
    localparam logic [31:0]       ERR_MAX    = 32'hFFFF_FFFF;

    // AR channel states
    localparam logic [0:0] AR_IDLE  = 1'b0;
    localparam logic [0:0] AR_ISSUE = 1'b1;
    // R channel states
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_CHECK  = 1'b1;

    logic [0:0]        ar_state_q, ar_state_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic [BLK_W-1:0]  ar_count_q, ar_count_d;

    logic [0:0]        r_state_q, r_state_d;
    logic [DW-1:0]     expected_q, expected_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [AW-1:0]     beat_addr_q, beat_addr_d;
    logic [31:0]       error_count_q, error_count_d;
    logic [AW-1:0]     first_error_addr_q, first_error_addr_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              busy_w;
    logic              start_ok_w;
    logic              beat_hs_w;
    logic              last_in_blk_w;
    logic              beat_bad_w;

    assign busy_w        = (r_state_q == R_CHECK);
    assign start_ok_w    = start && !busy_w;
    assign beat_hs_w     = busy_w && M_AXI_RVALID;
    assign last_in_blk_w = (beat_q == LAST_BEAT);
    // Several simultaneous faults on one beat still count as a single error.
    assign beat_bad_w    = (M_AXI_RDATA != expected_q) ||
                           (M_AXI_RRESP != 2'b00)      ||
                           (M_AXI_RLAST != last_in_blk_w);

    // AR machine: issue every burst address back to back, no gap between bursts.
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        ar_count_d = ar_count_q;
        case (ar_state_q)
            AR_IDLE: begin
                if (start_ok_w) begin
                    ar_state_d = AR_ISSUE;
                    araddr_d   = '0;
                    arvalid_d  = 1'b1;
                    ar_count_d = BLK_W'(1);
                end
            end
            AR_ISSUE: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    if (ar_count_q == LAST_BLK) begin
                        arvalid_d  = 1'b0;
                        ar_state_d = AR_IDLE;
                    end else begin
                        araddr_d   = araddr_q + ADDR_STEP;
                        ar_count_d = ar_count_q + BLK_W'(1);
                    end
                end
            end
            default: begin
                ar_state_d = AR_IDLE;
                arvalid_d  = 1'b0;
            end
        endcase
    end

    // R machine: check each beat, track burst position by beat count (not RLAST).
    always_comb begin
        r_state_d          = r_state_q;
        expected_d         = expected_q;
        beat_d             = beat_q;
        blk_d              = blk_q;
        beat_addr_d        = beat_addr_q;
        error_count_d      = error_count_q;
        first_error_addr_d = first_error_addr_q;
        done_d             = 1'b0;
        pass_d             = pass_q;
        case (r_state_q)
            R_IDLE: begin
                if (start_ok_w) begin
                    r_state_d          = R_CHECK;
                    expected_d         = FIRST_EXP;
                    beat_d             = '0;
                    blk_d              = BLK_W'(1);
                    beat_addr_d        = '0;
                    error_count_d      = '0;
                    first_error_addr_d = '0;
                    pass_d             = 1'b0;
                end
            end
            R_CHECK: begin
                if (beat_hs_w) begin
                    if (beat_bad_w) begin
                        if (error_count_q != ERR_MAX) begin
                            error_count_d = error_count_q + 32'd1;
                        end
                        // Count is cleared on start and saturates, so zero means no failure yet.
                        if (error_count_q == '0) begin
                            first_error_addr_d = beat_addr_q;
                        end
                    end
                    expected_d  = expected_q + DW'(1);
                    beat_addr_d = beat_addr_q + BEAT_STEP;
                    if (last_in_blk_w) begin
                        beat_d = '0;
                        blk_d  = blk_q + BLK_W'(1);
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                    if (last_in_blk_w && (blk_q == LAST_BLK)) begin
                        done_d    = 1'b1;
                        pass_d    = (error_count_d == '0);
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_q         <= AR_IDLE;
            araddr_q           <= '0;
            arvalid_q          <= 1'b0;
            ar_count_q         <= '0;
            r_state_q          <= R_IDLE;
            expected_q         <= '0;
            beat_q             <= '0;
            blk_q              <= '0;
            beat_addr_q        <= '0;
            error_count_q      <= '0;
            first_error_addr_q <= '0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
        end else begin
            ar_state_q         <= ar_state_d;
            araddr_q           <= araddr_d;
            arvalid_q          <= arvalid_d;
            ar_count_q         <= ar_count_d;
            r_state_q          <= r_state_d;
            expected_q         <= expected_d;
            beat_q             <= beat_d;
            blk_q              <= blk_d;
            beat_addr_q        <= beat_addr_d;
            error_count_q      <= error_count_d;
            first_error_addr_q <= first_error_addr_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
        end
    end

    assign busy             = busy_w;
    assign done             = done_q;
    assign pass             = pass_q;
    assign error_count      = error_count_q;
    assign first_error_addr = first_error_addr_q;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARLEN   = 8'(BEATS_PER_BLOCK - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BEAT_BYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_RREADY  = busy_w;

endmodule

`default_nettype wire

// File: tb/tb_check_ram.sv
// ============================================================================
//  Module   : tb_check_ram
//  Purpose  : Directed self-checking bench for check_ram with a small AXI
//             read-slave model that can inject data/response/framing faults
//             and apply AR/R backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_check_ram;

    localparam int DW    = 512;
    localparam int AW    = 16;
    localparam int BPB   = 64;
    localparam int NBLK  = 16;
    localparam int TOTAL = 1024;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          busy, done, pass;
    logic [31:0]   error_count;
    logic [AW-1:0] first_error_addr;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arid, arcache, arqos;
    logic          arlock;
    logic [2:0]    arprot;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    int n_assert = 0;
    int n_fail   = 0;

    // slave model state
    int            rb = 0;
    int            ar_acc = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            pass_id = 0;
    int            seen_id = 0;
    bit            ar_pend = 0;
    bit            r_pend = 0;
    bit            arv_prev = 0;
    logic [AW-1:0] ar_pend_addr = '0;
    logic [AW-1:0] ara_prev = '0;
    bit            bp_mode = 0;
    int            corrupt_beat = -1;
    int            resp_beat = -1;
    int            nolast_beat = -1;
    int            early_beat = -1;

    check_ram #(.DW(DW), .AW(AW), .FIRST_DATA(32'hC000_0000)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .error_count      (error_count),
        .first_error_addr (first_error_addr),
        .M_AXI_ARADDR     (araddr),
        .M_AXI_ARVALID    (arvalid),
        .M_AXI_ARREADY    (arready),
        .M_AXI_ARLEN      (arlen),
        .M_AXI_ARSIZE     (arsize),
        .M_AXI_ARBURST    (arburst),
        .M_AXI_ARID       (arid),
        .M_AXI_ARCACHE    (arcache),
        .M_AXI_ARQOS      (arqos),
        .M_AXI_ARLOCK     (arlock),
        .M_AXI_ARPROT     (arprot),
        .M_AXI_RDATA      (rdata),
        .M_AXI_RRESP      (rresp),
        .M_AXI_RLAST      (rlast),
        .M_AXI_RVALID     (rvalid),
        .M_AXI_RREADY     (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI read slave: everything driven at negedge; a handshake seen pending
    // at one negedge has completed by the next one.
    initial begin
        logic [DW-1:0] d;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        rdata   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_id != pass_id) begin
                seen_id  = pass_id;
                rb       = 0;
                ar_acc   = 0;
                done_cnt = 0;
            end
            if (!resetn) begin
                rb       = 0;
                ar_acc   = 0;
                ar_pend  = 0;
                r_pend   = 0;
                arv_prev = 0;
                arready  = 1'b0;
                rvalid   = 1'b0;
                rlast    = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (ar_pend) begin
                    check("ar_addr", 64'(ar_pend_addr), 64'(ar_acc * 4096));
                    ar_acc++;
                end
                if (r_pend) rb++;
                if (arv_prev && !ar_pend) begin
                    check("ar_hold_valid", 64'(arvalid), 64'd1);
                    check("ar_hold_addr", 64'(araddr), 64'(ara_prev));
                end
                if (arvalid) check("arvalid_needs_busy", 64'(busy), 64'd1);
                arready = bp_mode ? (((cyc / 3) % 2) == 0) : 1'b1;
                if (!(rvalid && !r_pend)) begin
                    rvalid = (rb < ar_acc * BPB) && (!bp_mode || ($urandom_range(0, 1) == 1));
                end
                d = {{(DW-32){1'b0}}, 32'hC000_0000} + DW'(rb);
                if (rb == corrupt_beat) d[0] = ~d[0];
                rdata = d;
                rresp = (rb == resp_beat) ? 2'b10 : 2'b00;
                rlast = (((rb % BPB) == BPB - 1) ^ (rb == nolast_beat)) ^ (rb == early_beat);
                ar_pend      = arvalid && arready;
                ar_pend_addr = araddr;
                r_pend       = rvalid && rready;
                arv_prev     = arvalid;
                ara_prev     = araddr;
            end
        end
    end

    task automatic start_pass();
        @(negedge clk);
        #1;
        pass_id++;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("start_arvalid", 64'(arvalid), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
        check("start_rready", 64'(rready), 64'd1);
        check("start_errcnt_clr", 64'(error_count), 64'd0);
        check("start_pass_clr", 64'(pass), 64'd0);
    endtask

    task automatic wait_rb(input int target);
        int n;
        n = 0;
        while (rb < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("reach_beat", 64'(rb >= target), 64'd1);
    endtask

    task automatic finish_checks(input bit exp_pass, input int exp_ec, input int exp_fea);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 6000);
        check("done_seen", 64'(done), 64'd1);
        check("pass", 64'(pass), 64'(exp_pass));
        check("error_count", 64'(error_count), 64'(exp_ec));
        check("first_error_addr", 64'(first_error_addr), 64'(exp_fea));
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check("done_single_cycle", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("beats_served", 64'(rb), 64'(TOTAL));
        check("ar_handshakes", 64'(ar_acc), 64'(NBLK));
        check("pass_held", 64'(pass), 64'(exp_pass));
    endtask

    task automatic check_reset_values();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_first_error_addr", 64'(first_error_addr), 64'd0);
    endtask

    task automatic clear_faults();
        corrupt_beat = -1;
        resp_beat    = -1;
        nolast_beat  = -1;
        early_beat   = -1;
        bp_mode      = 0;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        check("arlen", 64'(arlen), 64'd63);
        check("arsize", 64'(arsize), 64'd6);
        check("arburst", 64'(arburst), 64'd1);
        check("ar_misc_zero", 64'({arid, arcache, arqos, arlock, arprot}), 64'd0);
        #1 resetn = 1'b1;

        // clean pass
        clear_faults();
        start_pass();
        finish_checks(1'b1, 0, 0);

        // single data bit flipped on beat 37 -> 37*64 = 0x940
        clear_faults();
        corrupt_beat = 37;
        start_pass();
        finish_checks(1'b0, 1, 16'h0940);

        // RRESP error on 100, missing RLAST on 63, early RLAST on 70
        clear_faults();
        resp_beat   = 100;
        nolast_beat = 63;
        early_beat  = 70;
        start_pass();
        finish_checks(1'b0, 3, 16'h0FC0);

        // backpressure on AR and R
        clear_faults();
        bp_mode = 1;
        start_pass();
        finish_checks(1'b1, 0, 0);

        // start while busy is ignored; error on beat 20 -> 0x500 must survive
        clear_faults();
        corrupt_beat = 20;
        start_pass();
        wait_rb(500);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("busy_after_restart", 64'(busy), 64'd1);
        check("errcnt_after_restart", 64'(error_count), 64'd1);
        finish_checks(1'b0, 1, 16'h0500);

        // reset mid-pass with a recorded error, then a clean pass
        clear_faults();
        corrupt_beat = 10;
        start_pass();
        wait_rb(300);
        check("errcnt_before_reset", 64'(error_count), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_values();
        #1 resetn = 1'b1;
        clear_faults();
        start_pass();
        finish_checks(1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
